hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
//  Parametrised forwarding and hazard controller for the 5-stage MIPS pipeline.
//  Generates per-operand forwarding selects for NUM_SRC EX-stage source registers. MEM has priority over WB.
//  Detects load-use hazards in ID and runs a stall FSM. The FSM holds PC and IF/ID and injects ID/EX bubbles
//  for LOAD_USE_STALL cycles. Sits beside the ID/EX boundary and drives the EX operand muxes and the pipeline-register enables.
// PARAMETERS
//  REG_ADDR_W      5   register-address width
//  NUM_SRC         2   source operands per instruction (rs, rt, ...)
//  LOAD_USE_STALL  1   bubbles inserted per load-use hazard, 1..3
//  STALL_CNT_W     16  width of the saturating bubble counter
// PORTS
//  clk            in   1                   rising-edge clock
//  rst            in   1                   synchronous, active-high reset
//  ex_src         in   NUM_SRC*REG_ADDR_W  EX-stage source reg numbers; slot i = bits [i*W +: W]
//  id_src         in   NUM_SRC*REG_ADDR_W  ID-stage source reg numbers
//  id_src_used    in   NUM_SRC             slot i of id_src is read by the ID instruction
//  ex_dst         in   REG_ADDR_W          ID/EX destination register
//  ex_mem_read    in   1                   ID/EX instruction is a load
//  mem_dst        in   REG_ADDR_W          EX/MEM destination register
//  mem_reg_write  in   1                   EX/MEM writes the register file
//  wb_dst         in   REG_ADDR_W          MEM/WB destination register
//  wb_reg_write   in   1                   MEM/WB writes the register file
//  flush          in   1                   taken branch/jump: squash IF and ID
//  fwd_sel        out  2*NUM_SRC           slot i = bits [2i +: 2]: 00 regfile, 01 MEM ALU result, 10 WB result
//  pc_hold        out  1                   freeze PC
//  ifid_hold      out  1                   freeze IF/ID
//  idex_bubble    out  1                   load NOP into ID/EX
//  stall_count    out  STALL_CNT_W         total bubbles injected, saturating
// BEHAVIOUR
//  Forwarding (combinational, 0 latency), per slot i, independent of the FSM:
//   - mem_hit = mem_reg_write && mem_dst!=0 && mem_dst==ex_src[i].
//   - wb_hit  = wb_reg_write && wb_dst!=0 && wb_dst==ex_src[i].
//   - sel = mem_hit ? 01 : wb_hit ? 10 : 00. A WB hit is never suppressed unless mem_hit on the same slot.
//   - Value 11 is never produced.
//  Load-use detect (combinational):
//   - hz = ex_mem_read && ex_dst!=0 && OR_i(id_src_used[i] && id_src[i]==ex_dst).
//  FSM states IDLE, STALL. Down-counter rem, width 2.
//   - IDLE: if hz && !flush, assert pc_hold, ifid_hold and idex_bubble this cycle.
//     If LOAD_USE_STALL>1, go to STALL with rem=LOAD_USE_STALL-1; else stay in IDLE.
//   - IDLE: if hz && flush, flush wins. No hold, no bubble (the ID instruction is squashed anyway).
//   - STALL: assert all three outputs; rem--. When rem reaches 1, return to IDLE on the next edge.
//     hz is not re-evaluated while in STALL (ID is frozen).
//   - STALL with flush=1: deassert the outputs this cycle and go to IDLE. No bubble is counted this cycle.
//  Output drive:
//   - pc_hold, ifid_hold and idex_bubble are always equal.
//   - They are combinational from state, rem, hz and flush.
//  stall_count:
//   - Increments by 1 on each clk edge where idex_bubble=1.
//   - Holds at 2^STALL_CNT_W-1 (no wrap).
//  Reset:
//   - rst=1 at an edge: state=IDLE, rem=0, stall_count=0. This holds mid-stall too.
//   - While rst=1: pc_hold, ifid_hold and idex_bubble are forced to 0.
//   - fwd_sel stays purely combinational.
//  Register 0 never triggers forwarding or a stall.
// STRUCTURE
//  Package hazard_pkg holds:
//   - FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
//   - FSM state encoding IDLE/STALL.
//   - A function that extracts slot i from the packed register buses.
//  Sub-module fwd_slot_sel: one slot's mem/wb compare plus priority select. Generated NUM_SRC times.
//  The top level holds the hz reduction, the FSM, rem and stall_count.
// TESTING
//  - ex_src0=3, mem_dst=3/wr=1, wb_dst=3/wr=1 -> fwd_sel[1:0]=01.
//  - ex_src0=3, mem_dst=4/wr=1, wb_dst=3/wr=1 -> fwd_sel[1:0]=10. ex_src1=4 -> fwd_sel[3:2]=01.
//  - mem_dst=0/wr=1, ex_src0=0 -> 00. wb_reg_write=0, wb_dst=ex_src1 -> 00.
//  - LOAD_USE_STALL=1: ex_mem_read=1, ex_dst=5, id_src1=5, id_src_used=2'b10 -> stall for exactly 1 cycle,
//    stall_count 0->1. Same with id_src_used=2'b00 -> no stall.
//  - LOAD_USE_STALL=3: hazard -> 3 consecutive stall cycles. Repeat with flush in the 2nd cycle ->
//    2 bubbles total, IDLE after.
//  - rst in the STALL state -> next cycle outputs 0, stall_count=0.
//    STALL_CNT_W=4 with 20 hazards -> stall_count=15.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared encodings for the forwarding/hazard controller: forward selects,
// stall FSM states and a helper that pulls one register slot out of a packed bus.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    // Widest packed register bus get_slot accepts; narrower buses are zero-extended.
    localparam int SLOT_BUS_W = 256;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

    function automatic logic [31:0] get_slot(input logic [SLOT_BUS_W-1:0] bus,
                                             input int idx, input int w);
        logic [SLOT_BUS_W-1:0] sh;
        sh = bus >> (idx * w);
        return sh[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: register numbers and write
// flags in, operand forward selects and freeze/bubble controls out.
interface hazard_forward_ctrl_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_SRC     = 2,
    parameter int STALL_CNT_W = 16
);
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_src;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]            id_src_used;
    logic [REG_ADDR_W-1:0]         ex_dst;
    logic                          ex_mem_read;
    logic [REG_ADDR_W-1:0]         mem_dst;
    logic                          mem_reg_write;
    logic [REG_ADDR_W-1:0]         wb_dst;
    logic                          wb_reg_write;
    logic                          flush;
    logic [2*NUM_SRC-1:0]          fwd_sel;
    logic                          pc_hold;
    logic                          ifid_hold;
    logic                          idex_bubble;
    logic [STALL_CNT_W-1:0]        stall_count;

    modport master (
        output ex_src, id_src, id_src_used, ex_dst, ex_mem_read,
               mem_dst, mem_reg_write, wb_dst, wb_reg_write, flush,
        input  fwd_sel, pc_hold, ifid_hold, idex_bubble, stall_count
    );

    modport slave (
        input  ex_src, id_src, id_src_used, ex_dst, ex_mem_read,
               mem_dst, mem_reg_write, wb_dst, wb_reg_write, flush,
        output fwd_sel, pc_hold, ifid_hold, idex_bubble, stall_count
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_slot_sel.sv
// One EX operand's forward select: compares against EX/MEM and MEM/WB
// destinations, the younger MEM result taking priority.
module fwd_slot_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_ex_src,
    input  logic [REG_ADDR_W-1:0] i_mem_dst,
    input  logic                  i_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_dst,
    input  logic                  i_wb_reg_write,
    output logic [1:0]            o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // r0 is hardwired zero, so a write to it never carries a value worth forwarding.
    assign w_mem_hit = i_mem_reg_write && (i_mem_dst != '0) && (i_mem_dst == i_ex_src);
    assign w_wb_hit  = i_wb_reg_write  && (i_wb_dst  != '0) && (i_wb_dst  == i_ex_src);

    assign o_sel = w_mem_hit ? FWD_MEM : (w_wb_hit ? FWD_WB : FWD_NONE);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline: per-operand
// forward selects plus a stall FSM that freezes PC/IF-ID and bubbles ID/EX.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int NUM_SRC        = 2,
    parameter int LOAD_USE_STALL = 1,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_ctrl_if.slave bus
);

    localparam logic [1:0] REM_INIT  = 2'(LOAD_USE_STALL - 1);
    localparam bit         MULTI_BUB = (LOAD_USE_STALL > 1);

    logic [NUM_SRC-1:0][1:0] w_fwd_sel;
    logic [NUM_SRC-1:0]      w_id_match;
    logic                    w_hz;
    logic                    w_stall;

    stall_state_e            r_state;
    logic [1:0]              r_rem;
    logic [STALL_CNT_W-1:0]  r_stall_count;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
        logic [REG_ADDR_W-1:0] w_ex_slot;
        logic [REG_ADDR_W-1:0] w_id_slot;

        assign w_ex_slot = REG_ADDR_W'(get_slot(SLOT_BUS_W'(bus.ex_src), g, REG_ADDR_W));
        assign w_id_slot = REG_ADDR_W'(get_slot(SLOT_BUS_W'(bus.id_src), g, REG_ADDR_W));
        assign w_id_match[g] = bus.id_src_used[g] && (w_id_slot == bus.ex_dst);

        fwd_slot_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
            .i_ex_src        (w_ex_slot),
            .i_mem_dst       (bus.mem_dst),
            .i_mem_reg_write (bus.mem_reg_write),
            .i_wb_dst        (bus.wb_dst),
            .i_wb_reg_write  (bus.wb_reg_write),
            .o_sel           (w_fwd_sel[g])
        );
    end

    assign bus.fwd_sel = w_fwd_sel;
    assign w_hz = bus.ex_mem_read && (bus.ex_dst != '0) && (|w_id_match);

    // ID is frozen during STALL, so hz is only consulted from IDLE; flush always wins.
    always_comb begin
        w_stall = 1'b0;
        if (!rst && !bus.flush)
            w_stall = (r_state == ST_STALL) || ((r_state == ST_IDLE) && w_hz);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rem         <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + STALL_CNT_W'(1);
            case (r_state)
                ST_IDLE: begin
                    if (w_hz && !bus.flush && MULTI_BUB) begin
                        r_state <= ST_STALL;
                        r_rem   <= REM_INIT;
                    end
                end
                ST_STALL: begin
                    if (bus.flush || (r_rem <= 2'd1)) begin
                        r_state <= ST_IDLE;
                        r_rem   <= '0;
                    end else begin
                        r_rem <= r_rem - 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rem   <= '0;
                end
            endcase
        end
    end

    assign bus.pc_hold     = w_stall;
    assign bus.ifid_hold   = w_stall;
    assign bus.idex_bubble = w_stall;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench: forwarding priority, load-use stalls with 1 and 3 bubbles,
// flush interaction, reset mid-stall and counter saturation.
module tb_hazard_forward_ctrl;

    localparam int W = 5;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*W-1:0] ex_src, id_src;
    logic [N-1:0]   id_src_used;
    logic [W-1:0]   ex_dst, mem_dst, wb_dst;
    logic           ex_mem_read, mem_reg_write, wb_reg_write, flush;

    int total = 0;
    int bad   = 0;

    hazard_forward_ctrl_if #(.REG_ADDR_W(W), .NUM_SRC(N), .STALL_CNT_W(16)) if1 ();
    hazard_forward_ctrl_if #(.REG_ADDR_W(W), .NUM_SRC(N), .STALL_CNT_W(16)) if3 ();
    hazard_forward_ctrl_if #(.REG_ADDR_W(W), .NUM_SRC(N), .STALL_CNT_W(4))  if4 ();

    assign if1.ex_src = ex_src;   assign if3.ex_src = ex_src;   assign if4.ex_src = ex_src;
    assign if1.id_src = id_src;   assign if3.id_src = id_src;   assign if4.id_src = id_src;
    assign if1.id_src_used = id_src_used; assign if3.id_src_used = id_src_used; assign if4.id_src_used = id_src_used;
    assign if1.ex_dst = ex_dst;   assign if3.ex_dst = ex_dst;   assign if4.ex_dst = ex_dst;
    assign if1.ex_mem_read = ex_mem_read; assign if3.ex_mem_read = ex_mem_read; assign if4.ex_mem_read = ex_mem_read;
    assign if1.mem_dst = mem_dst; assign if3.mem_dst = mem_dst; assign if4.mem_dst = mem_dst;
    assign if1.mem_reg_write = mem_reg_write; assign if3.mem_reg_write = mem_reg_write; assign if4.mem_reg_write = mem_reg_write;
    assign if1.wb_dst = wb_dst;   assign if3.wb_dst = wb_dst;   assign if4.wb_dst = wb_dst;
    assign if1.wb_reg_write = wb_reg_write; assign if3.wb_reg_write = wb_reg_write; assign if4.wb_reg_write = wb_reg_write;
    assign if1.flush = flush;     assign if3.flush = flush;     assign if4.flush = flush;

    hazard_forward_ctrl #(.REG_ADDR_W(W), .NUM_SRC(N), .LOAD_USE_STALL(1), .STALL_CNT_W(16))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    hazard_forward_ctrl #(.REG_ADDR_W(W), .NUM_SRC(N), .LOAD_USE_STALL(3), .STALL_CNT_W(16))
        dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    hazard_forward_ctrl #(.REG_ADDR_W(W), .NUM_SRC(N), .LOAD_USE_STALL(1), .STALL_CNT_W(4))
        dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hz(input logic on);
        ex_mem_read = on;
        ex_dst      = 5'd5;
        id_src      = {5'd5, 5'd9};
        id_src_used = 2'b10;
    endtask

    initial begin
        rst = 1'b1;
        ex_src = '0; id_src = '0; id_src_used = '0; ex_dst = '0;
        mem_dst = '0; wb_dst = '0; ex_mem_read = 1'b0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; flush = 1'b0;

        // Reset with a live hazard: controls forced low, counter cleared
        set_hz(1'b1);
        tick();
        chk("rst_hold1", 32'({if1.pc_hold, if1.ifid_hold, if1.idex_bubble}), 32'd0);
        chk("rst_hold3", 32'({if3.pc_hold, if3.ifid_hold, if3.idex_bubble}), 32'd0);
        chk("rst_cnt1", 32'(if1.stall_count), 32'd0);
        set_hz(1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_cnt_after", 32'(if1.stall_count), 32'd0);

        // Forwarding
        ex_src = {5'd4, 5'd3}; mem_dst = 5'd3; mem_reg_write = 1'b1; wb_dst = 5'd3; wb_reg_write = 1'b1;
        #1 chk("fwd_mem_prio", 32'(if1.fwd_sel), 32'h1);
        mem_dst = 5'd4;
        #1 chk("fwd_wb_and_mem", 32'(if1.fwd_sel), 32'h6);
        ex_src = {5'd7, 5'd0}; mem_dst = 5'd0; wb_dst = 5'd7; wb_reg_write = 1'b0;
        #1 chk("fwd_r0_nowr", 32'(if1.fwd_sel), 32'h0);
        wb_reg_write = 1'b1;
        #1 chk("fwd_wb_slot1", 32'(if1.fwd_sel), 32'h8);
        ex_src = {5'd7, 5'd7}; mem_dst = 5'd7;
        #1 chk("fwd_mem_both", 32'(if1.fwd_sel), 32'h5);
        mem_reg_write = 1'b0; wb_dst = 5'd0;
        #1 chk("fwd_wb_r0", 32'(if1.fwd_sel), 32'h0);
        chk("fwd_no_stall", 32'(if1.pc_hold), 32'd0);

        // Load-use, 1 bubble
        set_hz(1'b1);
        #1 chk("lu1_hold", 32'({if1.pc_hold, if1.ifid_hold, if1.idex_bubble}), 32'h7);
        tick();
        set_hz(1'b0);
        #1 chk("lu1_release", 32'({if1.pc_hold, if1.ifid_hold, if1.idex_bubble}), 32'h0);
        chk("lu1_cnt", 32'(if1.stall_count), 32'd1);
        set_hz(1'b1); id_src_used = 2'b00;
        #1 chk("lu1_unused", 32'(if1.pc_hold), 32'd0);
        id_src_used = 2'b11; ex_dst = 5'd0; id_src = '0;
        #1 chk("lu1_r0", 32'(if1.pc_hold), 32'd0);
        tick();
        set_hz(1'b0);
        #1 chk("lu1_cnt_hold", 32'(if1.stall_count), 32'd1);

        // Load-use, 3 bubbles
        rst = 1'b1; tick(); rst = 1'b0;
        set_hz(1'b1);
        #1 chk("lu3_c1", 32'({if3.pc_hold, if3.ifid_hold, if3.idex_bubble}), 32'h7);
        tick(); set_hz(1'b0);
        #1 chk("lu3_c2", 32'({if3.pc_hold, if3.ifid_hold, if3.idex_bubble}), 32'h7);
        tick();
        #1 chk("lu3_c3", 32'({if3.pc_hold, if3.ifid_hold, if3.idex_bubble}), 32'h7);
        tick();
        #1 chk("lu3_done", 32'({if3.pc_hold, if3.ifid_hold, if3.idex_bubble}), 32'h0);
        chk("lu3_cnt", 32'(if3.stall_count), 32'd3);

        // Flush during the second STALL cycle cuts it to 2 bubbles
        set_hz(1'b1);
        #1 chk("lu3f_c1", 32'(if3.idex_bubble), 32'd1);
        tick(); set_hz(1'b0);
        #1 chk("lu3f_c2", 32'(if3.idex_bubble), 32'd1);
        tick(); flush = 1'b1;
        #1 chk("lu3f_flush", 32'({if3.pc_hold, if3.ifid_hold, if3.idex_bubble}), 32'h0);
        tick(); flush = 1'b0;
        #1 chk("lu3f_idle", 32'(if3.idex_bubble), 32'd0);
        chk("lu3f_cnt", 32'(if3.stall_count), 32'd5);

        // Flush in IDLE beats a hazard
        set_hz(1'b1); flush = 1'b1;
        #1 chk("idle_flush", 32'(if3.pc_hold), 32'd0);
        tick(); set_hz(1'b0); flush = 1'b0;
        #1 chk("idle_flush_cnt", 32'(if3.stall_count), 32'd5);
        chk("idle_flush_state", 32'(if3.pc_hold), 32'd0);

        // Reset in STALL
        set_hz(1'b1);
        tick(); set_hz(1'b0); rst = 1'b1;
        #1 chk("rst_stall_forced", 32'({if3.pc_hold, if3.ifid_hold, if3.idex_bubble}), 32'h0);
        tick(); rst = 1'b0;
        #1 chk("rst_stall_hold", 32'({if3.pc_hold, if3.ifid_hold, if3.idex_bubble}), 32'h0);
        chk("rst_stall_cnt", 32'(if3.stall_count), 32'd0);

        // Saturation: 20 consecutive bubbles
        set_hz(1'b1);
        repeat (20) tick();
        set_hz(1'b0);
        #1 chk("sat_cnt4", 32'(if4.stall_count), 32'd15);
        chk("sat_cnt16", 32'(if1.stall_count), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
